// File: rtl/sum_pipeline.sv
// Two-stage handshake pipeline that finishes a prefix-carry addition from per-bit g/p/h cells.
// Optional OVERFLOW_FLAG_EN macro adds a registered signed-overflow output ovf.
module sum_pipeline #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] h,
    input  logic             cin,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef OVERFLOW_FLAG_EN
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready
);

    function automatic logic [WIDTH:0] carry_chain(
        input logic [WIDTH-1:0] gv,
        input logic [WIDTH-1:0] pv,
        input logic             c0
    );
        logic [WIDTH:0] c;
        c    = {(WIDTH+1){1'b0}};
        c[0] = c0;
        for (int i = 0; i < WIDTH; i++) begin
            c[i+1] = gv[i] | (pv[i] & c[i]);
        end
        return c;
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] g_q, g_d, p_q, p_d, h_q, h_d;
    logic             cin_q, cin_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef OVERFLOW_FLAG_EN
    logic             ovf_q, ovf_d;
`endif
    logic             s2_load_s, s1_move_s, in_ready_s, s1_accept_s;
    logic [WIDTH:0]   carry_s;

    // Handshake: S2 frees up when empty or drained; S1 can accept when it empties the same cycle.
    always_comb begin
        s2_load_s   = ~s2_valid_q | out_ready;
        s1_move_s   = s1_valid_q & s2_load_s;
        in_ready_s  = ~s1_valid_q | s2_load_s;
        s1_accept_s = in_valid & in_ready_s;
    end

    assign in_ready  = in_ready_s;
    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef OVERFLOW_FLAG_EN
    assign ovf       = ovf_q;
`endif

    // Stage 1 next state: capture a new operand set, or go empty once its contents move on.
    always_comb begin
        s1_valid_d = s1_valid_q;
        g_d        = g_q;
        p_d        = p_q;
        h_d        = h_q;
        cin_d      = cin_q;
        if (s1_accept_s) begin
            s1_valid_d = 1'b1;
            g_d        = g;
            p_d        = p;
            h_d        = h;
            cin_d      = cin;
        end else if (s1_move_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage 2 next state: resolve carries from stage 1; data holds whenever nothing new arrives.
    always_comb begin
        carry_s    = carry_chain(g_q, p_q, cin_q);
        s2_valid_d = s2_valid_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
`ifdef OVERFLOW_FLAG_EN
        ovf_d      = ovf_q;
`endif
        if (s2_load_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                sum_d  = h_q ^ carry_s[WIDTH-1:0];
                cout_d = carry_s[WIDTH];
`ifdef OVERFLOW_FLAG_EN
                ovf_d  = carry_s[WIDTH] ^ carry_s[WIDTH-1];
`endif
            end else begin
                sum_d  = sum_q;
                cout_d = cout_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Pipeline registers; reset empties both stages and clears the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            g_q        <= {WIDTH{1'b0}};
            p_q        <= {WIDTH{1'b0}};
            h_q        <= {WIDTH{1'b0}};
            cin_q      <= 1'b0;
            s2_valid_q <= 1'b0;
            sum_q      <= {WIDTH{1'b0}};
            cout_q     <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            s1_valid_q <= s1_valid_d;
            g_q        <= g_d;
            p_q        <= p_d;
            h_q        <= h_d;
            cin_q      <= cin_d;
            s2_valid_q <= s2_valid_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
`ifdef OVERFLOW_FLAG_EN
            ovf_q      <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_sum_pipeline.sv
// Directed, table-driven bench for sum_pipeline (WIDTH=6), plus stall, drain and reset sequences.
module tb_sum_pipeline;

    localparam int W = 6;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] g, p, h;
    logic         cin, in_valid, in_ready;
    logic [W-1:0] sum;
    logic         cout, out_valid, out_ready;
`ifdef OVERFLOW_FLAG_EN
    logic         ovf;
`endif

    sum_pipeline #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .g         (g),
        .p         (p),
        .h         (h),
        .cin       (cin),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef OVERFLOW_FLAG_EN
        .ovf       (ovf),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         ci;
        logic [W-1:0] exp_sum;
        logic         exp_cout;
        logic         exp_ovf;
    } vec_t;

    vec_t vecs[8];
    int   n_checks;
    int   n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v, input logic vld);
        g        = v.x & v.y;
        p        = v.x | v.y;
        h        = v.x ^ v.y;
        cin      = v.ci;
        in_valid = vld;
    endtask

    task automatic check_out(input vec_t v, input string tag);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, ".sum"}, {26'd0, sum}, {26'd0, v.exp_sum});
        check({tag, ".cout"}, {31'd0, cout}, {31'd0, v.exp_cout});
`ifdef OVERFLOW_FLAG_EN
        check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, v.exp_ovf});
`endif
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        // x, y, cin, expected sum, cout, signed overflow
        vecs[0] = '{6'd23, 6'd41, 1'b0, 6'd0,  1'b1, 1'b0};
        vecs[1] = '{6'd5,  6'd3,  1'b1, 6'd9,  1'b0, 1'b0};
        vecs[2] = '{6'd31, 6'd1,  1'b0, 6'd32, 1'b0, 1'b1};
        vecs[3] = '{6'd0,  6'd0,  1'b0, 6'd0,  1'b0, 1'b0};
        vecs[4] = '{6'd63, 6'd63, 1'b1, 6'd63, 1'b1, 1'b0};
        vecs[5] = '{6'd32, 6'd32, 1'b0, 6'd0,  1'b1, 1'b1};
        vecs[6] = '{6'd10, 6'd20, 1'b1, 6'd31, 1'b0, 1'b0};
        vecs[7] = '{6'd63, 6'd0,  1'b1, 6'd0,  1'b1, 1'b0};

        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(vecs[3], 1'b0);
        #12;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.sum", {26'd0, sum}, 32'd0);
        check("rst.cout", {31'd0, cout}, 32'd0);
`ifdef OVERFLOW_FLAG_EN
        check("rst.ovf", {31'd0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;
        step();
        check("rst.in_ready", {31'd0, in_ready}, 32'd1);

        // Back-to-back stream: result for vector k is visible two edges after it is driven.
        for (int cyc = 0; cyc <= 10; cyc++) begin
            if (cyc >= 2 && cyc <= 9) begin
                check_out(vecs[cyc-2], $sformatf("stream%0d", cyc - 2));
            end else begin
                check($sformatf("stream_idle%0d", cyc), {31'd0, out_valid}, 32'd0);
            end
            if (cyc < 8) begin
                drive(vecs[cyc], 1'b1);
                check($sformatf("stream_in_ready%0d", cyc), {31'd0, in_ready}, 32'd1);
            end else begin
                drive(vecs[3], 1'b0);
            end
            step();
        end

        // Stall: two inputs fill both stages, third is refused.
        out_ready = 1'b0;
        drive(vecs[0], 1'b1);
        check("stall.ready_a", {31'd0, in_ready}, 32'd1);
        step();
        drive(vecs[1], 1'b1);
        check("stall.ready_b", {31'd0, in_ready}, 32'd1);
        step();
        drive(vecs[2], 1'b1);
        check("stall.ready_c", {31'd0, in_ready}, 32'd0);
        check_out(vecs[0], "stall.hold0");
        step();
        check("stall.ready_c2", {31'd0, in_ready}, 32'd0);
        check_out(vecs[0], "stall.hold1");

        // Release: drain A, move B and accept C in the same cycle.
        out_ready = 1'b1;
        #1;
        check("drain.ready_c", {31'd0, in_ready}, 32'd1);
        step();
        drive(vecs[3], 1'b0);
        check_out(vecs[1], "drain.b");
        step();
        check_out(vecs[2], "drain.c");
        step();
        check("drain.empty", {31'd0, out_valid}, 32'd0);

        // Mid-operation reset with both stages full.
        out_ready = 1'b0;
        drive(vecs[4], 1'b1);
        step();
        drive(vecs[6], 1'b1);
        step();
        drive(vecs[3], 1'b0);
        check_out(vecs[4], "prerst");
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst.sum", {26'd0, sum}, 32'd0);
        check("midrst.cout", {31'd0, cout}, 32'd0);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check("postrst.flushed", {31'd0, out_valid}, 32'd0);
        drive(vecs[2], 1'b1);
        check("postrst.in_ready", {31'd0, in_ready}, 32'd1);
        step();
        drive(vecs[3], 1'b0);
        check("postrst.lat1", {31'd0, out_valid}, 32'd0);
        step();
        check_out(vecs[2], "postrst");
        step();
        check("postrst.empty", {31'd0, out_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
